imem_boot_ctrl: RTL



---
 rtl/imem_boot_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/imem_boot_ctrl.sv
// Boot/run sequencer: holds the core in reset, streams a program into the
// instruction RAM, then runs the core until halt or budget expiry.
// Optional running load checksum is enabled by defining IMEM_BOOT_CHECKSUM_EN.
module imem_boot_ctrl #(
  parameter int          ADDR_W     = 12,
  parameter int          DATA_W     = 32,
  parameter int unsigned MAX_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              run_start,
  input  logic              halt_req,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              core_rst_n,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   word_count,
  output logic [31:0]       cycle_count,
  output logic              err_overflow,
  output logic              timeout,
  output logic [31:0]       ld_checksum
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_RUN = 2'd2} state_e;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [31:0]     MAXC  = MAX_CYCLES;
  localparam logic [31:0]     MAXM1 = MAXC - 32'd1;

  state_e              state_q, state_d;
  logic                ld_ready_q, ld_ready_d;
  logic                core_rst_n_q, core_rst_n_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [ADDR_W:0]     wcnt_q, wcnt_d;
  logic [31:0]         ccnt_q, ccnt_d;
  logic                ovf_q, ovf_d;
  logic                to_q, to_d;
  logic                xfer;

  assign xfer = (state_q == S_LOAD) && ld_valid && ld_ready_q;

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wcnt_d  = wcnt_q;
    ccnt_d  = ccnt_q;
    ovf_d   = ovf_q;
    to_d    = to_q;
    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d = S_LOAD;
          wcnt_d  = '0;
          ovf_d   = 1'b0;
        end else if (run_start && (wcnt_q != '0)) begin
          state_d = S_RUN;
          ccnt_d  = '0;
          to_d    = 1'b0;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          we_d    = 1'b1;
          waddr_d = wcnt_q[ADDR_W-1:0];
          wdata_d = ld_data;
          wcnt_d  = wcnt_q + 1'b1;
          if (ld_last) state_d = S_IDLE;
        end else if (ld_valid && (wcnt_q == DEPTH)) begin
          ovf_d   = 1'b1;
          state_d = S_IDLE;
        end
        if (halt_req) state_d = S_IDLE;
      end
      S_RUN: begin
        if (ccnt_q != '1) ccnt_d = ccnt_q + 32'd1;
        if (halt_req) state_d = S_IDLE;
        // Expiry wins over a coincident halt so timeout is still reported.
        if ((MAX_CYCLES != 0) && (ccnt_q == MAXM1)) begin
          ccnt_d  = MAXC;
          to_d    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ld_ready_d   = (state_d == S_LOAD) && (wcnt_d < DEPTH);
    core_rst_n_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ld_ready_q   <= 1'b0;
      core_rst_n_q <= 1'b0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      wcnt_q       <= '0;
      ccnt_q       <= '0;
      ovf_q        <= 1'b0;
      to_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      ld_ready_q   <= ld_ready_d;
      core_rst_n_q <= core_rst_n_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      wcnt_q       <= wcnt_d;
      ccnt_q       <= ccnt_d;
      ovf_q        <= ovf_d;
      to_q         <= to_d;
    end
  end

`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if ((state_q == S_IDLE) && load_start) csum_d = '0;
    else if (xfer)                          csum_d = csum_q + 32'(ld_data);
  end

  always_ff @(posedge clk) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_d;
  end

  assign ld_checksum = csum_q;
`else
  assign ld_checksum = '0;
`endif

  assign state        = state_q;
  assign ld_ready     = ld_ready_q;
  assign core_rst_n   = core_rst_n_q;
  assign imem_we      = we_q;
  assign imem_waddr   = waddr_q;
  assign imem_wdata   = wdata_q;
  assign word_count   = wcnt_q;
  assign cycle_count  = ccnt_q;
  assign err_overflow = ovf_q;
  assign timeout      = to_q;

endmodule
